// File: rtl/xst_arb.sv
// Two-requester round-robin arbiter and transfer sequencer for the xst shift engine.
// Grants the engine, loads it in normal or reversed order, waits for idle, reads back.
module xst_arb (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        req_a_i,
    input  logic        req_b_i,
    input  logic        rev_a_i,
    input  logic        rev_b_i,
    input  logic [63:0] dat_a_i,
    input  logic [63:0] dat_b_i,
    input  logic [5:0]  bits_a_i,
    input  logic [5:0]  bits_b_i,
    input  logic [15:0] baud_a_i,
    input  logic [15:0] baud_b_i,
    output logic        gnt_a_o,
    output logic        gnt_b_o,
    output logic        done_a_o,
    output logic        done_b_o,
    output logic [63:0] rdat_o,
    output logic        busy_o,
    output logic        xst_we_o,
    output logic        xst_wer_o,
    output logic        xst_oe_o,
    output logic        xst_oer_o,
    output logic [63:0] xst_dat_o,
    output logic [5:0]  xst_bits_o,
    output logic [15:0] xst_baud_o,
    input  logic        xst_idle_i,
    input  logic [63:0] xst_dat_i
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_ARM,
        S_WAIT,
        S_READ
    } state_t;

    state_t      state_reg;
    state_t      state_next;
    logic        last_b_reg;
    logic        owner_b_reg;
    logic        rev_reg;
    logic [63:0] dat_reg;
    logic [5:0]  bits_reg;
    logic [15:0] baud_reg;
    logic [63:0] rdat_reg;
    logic [1:0]  done_reg;
    logic [1:0]  gnt_vec;
    logic        grant;
    logic        win_b;

    // Grant only into an idle engine so an in-flight transfer is never overwritten.
    assign grant = (state_reg == S_IDLE) && xst_idle_i && (req_a_i || req_b_i);
    // On a tie the requester that was not served last wins.
    assign win_b = req_b_i && (!req_a_i || !last_b_reg);

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE: if (grant) state_next = S_LOAD;
            S_LOAD: state_next = S_ARM;
            S_ARM:  state_next = S_WAIT;
            S_WAIT: if (xst_idle_i) state_next = S_READ;
            S_READ: state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_reg   <= S_IDLE;
            last_b_reg  <= 1'b1;
            owner_b_reg <= 1'b0;
            rev_reg     <= 1'b0;
            dat_reg     <= '0;
            bits_reg    <= '0;
            baud_reg    <= '0;
            rdat_reg    <= '0;
            done_reg    <= '0;
        end else begin
            state_reg <= state_next;
            if (grant) begin
                owner_b_reg <= win_b;
                rev_reg     <= win_b ? rev_b_i  : rev_a_i;
                dat_reg     <= win_b ? dat_b_i  : dat_a_i;
                bits_reg    <= win_b ? bits_b_i : bits_a_i;
                baud_reg    <= win_b ? baud_b_i : baud_a_i;
            end
            if (state_reg == S_READ) begin
                rdat_reg   <= xst_dat_i;
                last_b_reg <= owner_b_reg;
                done_reg   <= owner_b_reg ? 2'b10 : 2'b01;
            end else begin
                done_reg   <= 2'b00;
            end
        end
    end

    // Per-requester grant decode; index 0 is A, index 1 is B.
    for (genvar gi = 0; gi < 2; gi++) begin : g_req
        assign gnt_vec[gi] = (state_reg == S_LOAD) && (owner_b_reg == 1'(gi));
    end

    assign gnt_a_o    = gnt_vec[0];
    assign gnt_b_o    = gnt_vec[1];
    assign done_a_o   = done_reg[0];
    assign done_b_o   = done_reg[1];
    assign rdat_o     = rdat_reg;
    assign busy_o     = (state_reg != S_IDLE);
    assign xst_we_o   = (state_reg == S_LOAD) && !rev_reg;
    assign xst_wer_o  = (state_reg == S_LOAD) &&  rev_reg;
    assign xst_oe_o   = (state_reg == S_READ) && !rev_reg;
    assign xst_oer_o  = (state_reg == S_READ) &&  rev_reg;
    assign xst_dat_o  = dat_reg;
    assign xst_bits_o = bits_reg;
    assign xst_baud_o = baud_reg;

endmodule
